axi4lite_req_arbiter: RTL and testbench

- Round-robin arbiter sharing the single AXI4-Lite master user interface (start_write/start_read/addr/data/done) among NUM_REQ local requesters.
- Sits between requesters and axi4lite_master. It latches one request, issues a one-cycle start pulse, and waits for done. It then returns read data and an ack pulse to the winner.

---
 rtl/axi4lite_req_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_axi4lite_req_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_req_arbiter.sv
// -----------------------------------------------------------------------------
// axi4lite_req_arbiter
//
// Round-robin arbiter that shares one AXI4-Lite master user interface
// (start_write / start_read / addr / wdata / done) among NUM_REQ local
// requesters. One request is latched at a time: the winner gets a one-hot
// grant, the master gets a single-cycle start pulse, and when the master
// reports done the read data and a one-cycle ack go back to the winner.
//
// State sequence: IDLE -> ISSUE (1 cycle) -> WAIT -> RESP (1 cycle) -> IDLE.
// Every output is a register.
//
// Optional feature (macro AXI4LITE_ARB_TIMEOUT_EN):
//   defined   - WAIT watchdog; after TIMEOUT_CYCLES WAIT cycles without
//               m_done the transaction completes with rsp_err=1, rsp_rdata=0.
//   undefined - WAIT waits indefinitely and rsp_err is tied to 0.
//
// Ports:
//   clk, rst       clock (rising edge) and asynchronous active-high reset
//   req            per-requester request level
//   req_we         per-requester direction, 1=write 0=read
//   req_addr       packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata      packed write data, requester i at [i*DATA_W +: DATA_W]
//   gnt            one-hot grant, held from ISSUE through RESP
//   ack            one-cycle completion pulse to the granted requester
//   rsp_rdata      read data, valid with ack, held until the next ack
//   rsp_err        completion error flag, valid with ack
//   busy           high whenever the arbiter is not idle
//   m_start_write  single-cycle write start to the master
//   m_start_read   single-cycle read start to the master
//   m_addr         address to the master
//   m_wdata        write data to the master
//   m_rdata        read data from the master
//   m_done         transaction done from the master
// -----------------------------------------------------------------------------
module axi4lite_req_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 2,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      busy,
    output logic                      m_start_write,
    output logic                      m_start_read,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [DATA_W-1:0]         m_wdata,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic                      m_done
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("axi4lite_req_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   last;      // most recent winner; the scan starts just above it
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   cand;
    logic               found;
    logic [NUM_REQ-1:0] win_onehot;
    logic               win_we;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;

`ifdef AXI4LITE_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] wait_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    // Round-robin pick: first set req scanning last+1, last+2, ... modulo
    // NUM_REQ, so the previous winner is considered last.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write so
        // no path leaves it unassigned and no latch is inferred.
        found  = 1'b0;
        winner = last;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Field mux for the chosen requester.
    always_comb begin
        win_onehot = '0;
        win_we     = 1'b0;
        win_addr   = '0;
        win_wdata  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IDX_W'(i)) begin
                win_onehot[i] = 1'b1;
                win_we        = req_we[i];
                win_addr      = req_addr[i*ADDR_W +: ADDR_W];
                win_wdata     = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            last          <= IDX_W'(NUM_REQ - 1);
            gnt           <= '0;
            ack           <= '0;
            rsp_rdata     <= '0;
            busy          <= 1'b0;
            m_start_write <= 1'b0;
            m_start_read  <= 1'b0;
            m_addr        <= '0;
            m_wdata       <= '0;
`ifdef AXI4LITE_ARB_TIMEOUT_EN
            rsp_err       <= 1'b0;
            wait_cnt      <= '0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            m_start_write <= 1'b0;
            m_start_read  <= 1'b0;
            ack           <= '0;

            case (state)
                S_IDLE: begin
                    // A done still high from the previous transaction must not
                    // be mistaken for completion of a new one.
                    if (found && !m_done) begin
                        gnt           <= win_onehot;
                        last          <= winner;
                        m_addr        <= win_addr;
                        m_wdata       <= win_wdata;
                        m_start_write <= win_we;
                        m_start_read  <= !win_we;
                        busy          <= 1'b1;
                        state         <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
`ifdef AXI4LITE_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (m_done) begin
                        rsp_rdata <= m_rdata;
`ifdef AXI4LITE_ARB_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                        ack       <= gnt;
                        state     <= S_RESP;
                    end
`ifdef AXI4LITE_ARB_TIMEOUT_EN
                    // wait_cnt counts completed WAIT cycles; this is the last one.
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        ack       <= gnt;
                        state     <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                S_RESP: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi4lite_req_arbiter
//
// Self-checking bench. A transaction-level reference model predicts, edge by
// edge, which requester wins, when the start pulse, ack and release occur
// (as offsets from the grant edge and the first done edge), and what data and
// error flag are returned. A small master responder in the bench drives
// m_done / m_rdata on a schedule chosen at the model's grant time.
// -----------------------------------------------------------------------------
module tb_axi4lite_req_arbiter;

    localparam int N   = 3;
    localparam int AW  = 2;
    localparam int DW  = 8;
    localparam int TO  = 10;
    localparam int BIG = 1 << 30;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            busy;
    logic            m_start_write;
    logic            m_start_read;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [DW-1:0]   m_rdata;
    logic            m_done;

    axi4lite_req_arbiter #(
        .NUM_REQ        (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .gnt           (gnt),
        .ack           (ack),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .busy          (busy),
        .m_start_write (m_start_write),
        .m_start_read  (m_start_read),
        .m_addr        (m_addr),
        .m_wdata       (m_wdata),
        .m_rdata       (m_rdata),
        .m_done        (m_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            k;          // clock edge counter
    bit            mb;         // a transaction is in flight
    int            mw;         // its winner
    int            me;         // edge at which it was granted
    int            mresp;      // edge at which completion was seen, -1 if not yet
    bit            mwe;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwdata;
    logic [DW-1:0] mrdata;
    bit            merr;
    int            mlast;

    // master responder schedule
    int            done_from;
    int            done_len;
    logic [DW-1:0] done_data;
    int            fixed_lat   = -1;   // -1 random 1..4, -2 never respond
    int            fixed_hold  = 0;    // extra cycles done stays high
    int            fixed_rdata = -1;   // -1 random

    task automatic model_reset();
        mb        = 1'b0;
        mw        = 0;
        me        = 0;
        mresp     = -1;
        mwe       = 1'b0;
        maddr     = '0;
        mwdata    = '0;
        mrdata    = '0;
        merr      = 1'b0;
        mlast     = N - 1;
        done_from = BIG;
        done_len  = 0;
    endtask

    task automatic model_update();
        int lat;
        if (!mb) begin
            if (req != '0 && !m_done) begin
                for (int i = 1; i <= N; i++) begin
                    int c;
                    c = (mlast + i) % N;
                    if (req[c]) begin
                        mw = c;
                        break;
                    end
                end
                mlast  = mw;
                mwe    = req_we[mw];
                maddr  = req_addr[mw*AW +: AW];
                mwdata = req_wdata[mw*DW +: DW];
                mb     = 1'b1;
                me     = k;
                mresp  = -1;
                lat    = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(1, 4));
                done_from = (fixed_lat == -2) ? BIG : k + 1 + lat;
                done_len  = 1 + fixed_hold;
                done_data = (fixed_rdata >= 0) ? DW'(fixed_rdata) : DW'($urandom);
            end
        end else if (mresp < 0) begin
            if (k >= me + 2 && m_done) begin
                mresp  = k;
                mrdata = m_rdata;
                merr   = 1'b0;
            end
`ifdef AXI4LITE_ARB_TIMEOUT_EN
            else if (k == me + 1 + TO) begin
                mresp  = k;
                mrdata = '0;
                merr   = 1'b1;
            end
`endif
        end else if (k == mresp + 1) begin
            mb = 1'b0;
        end
    endtask

    task automatic compare();
        logic [N-1:0] eg;
        bit           acking;
        eg     = mb ? (N'(1) << mw) : '0;
        acking = mb && (k == mresp);
        check("gnt", 32'(gnt), 32'(eg));
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        check("ack", 32'(ack), acking ? 32'(eg) : 32'd0);
        check("busy", 32'(busy), 32'(mb));
        check("start_write", 32'(m_start_write), 32'(mb && k == me && mwe));
        check("start_read", 32'(m_start_read), 32'(mb && k == me && !mwe));
        check("rsp_rdata", 32'(rsp_rdata), 32'(mrdata));
        if (mb) begin
            check("m_addr", 32'(m_addr), 32'(maddr));
            check("m_wdata", 32'(m_wdata), 32'(mwdata));
        end
        if (acking) check("rsp_err", 32'(rsp_err), 32'(merr));
    endtask

    task automatic drive_master();
        m_done  = (k + 1 >= done_from) && (k + 1 < done_from + done_len);
        m_rdata = m_done ? done_data : DW'($urandom);
    endtask

    // One clock: model sees the inputs that the DUT sees at this edge, then
    // outputs are sampled 1 ns later and the master inputs for the next edge
    // are driven.
    task automatic step();
        @(posedge clk);
        k++;
        model_update();
        #1;
        compare();
        drive_master();
    endtask

    task automatic check_zero();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start_write", 32'(m_start_write), 32'd0);
        check("rst_start_read", 32'(m_start_read), 32'd0);
        check("rst_m_addr", 32'(m_addr), 32'd0);
        check("rst_m_wdata", 32'(m_wdata), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
    endtask

    // Asserts reset between clock edges, checks the asynchronous clear, holds
    // reset over two edges and releases it just after an edge.
    task automatic apply_reset();
        #2;
        rst = 1'b1;
        #1;
        check_zero();
        model_reset();
        req    = '0;
        m_done = 1'b0;
        repeat (2) begin
            @(posedge clk);
            k++;
        end
        #1;
        rst = 1'b0;
    endtask

    // Runs until the DUT acks (bounded), tallying start pulses seen.
    task automatic run_txn(input bit drop, output logic [N-1:0] ackv, output int nsw,
                           output int nsr, output int lat_steps,
                           output logic [DW-1:0] rd, output logic er);
        int s;
        int st;
        bit seen;
        s = 0; st = -1; seen = 1'b0;
        ackv = '0; nsw = 0; nsr = 0; lat_steps = -1; rd = '0; er = 1'b0;
        while (!seen && s < 60) begin
            step();
            s++;
            if (m_start_write) begin nsw++; st = s; end
            if (m_start_read)  begin nsr++; st = s; end
            if (ack != '0) begin
                seen      = 1'b1;
                ackv      = ack;
                rd        = rsp_rdata;
                er        = rsp_err;
                lat_steps = (st >= 0) ? s - st : -1;
                if (drop) req = req & ~ack;
            end
        end
        check("txn_completed", 32'(seen), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        logic [N-1:0]  ackv;
        int            nsw, nsr, lat;
        logic [DW-1:0] rd;
        logic          er;
        int            exp_order[4];
        int            first;
        bit            seen_busy;

        exp_order = '{0, 1, 0, 1};
        k         = 0;
        rst       = 1'b0;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        m_done    = 1'b0;
        m_rdata   = '0;
        model_reset();
        apply_reset();

        // ---- single write from requester 0, done 3 cycles after start ----
        fixed_lat = 3;
        req_we[0] = 1'b1;
        req_addr[0*AW +: AW]  = AW'(2);
        req_wdata[0*DW +: DW] = 8'hA5;
        req[0] = 1'b1;
        run_txn(1'b1, ackv, nsw, nsr, lat, rd, er);
        check("wr_ack", 32'(ackv), 32'h1);
        check("wr_start_write_pulses", 32'(nsw), 32'd1);
        check("wr_start_read_pulses", 32'(nsr), 32'd0);
        check("wr_start_to_ack", 32'(lat), 32'd4);
        check("wr_err", 32'(er), 32'd0);
        check("wr_m_addr", 32'(m_addr), 32'd2);
        check("wr_m_wdata", 32'(m_wdata), 32'hA5);

        // ---- single read from requester 1 returning 0x3C ----
        fixed_lat   = -1;
        fixed_rdata = 8'h3C;
        req_we[1]   = 1'b0;
        req_addr[1*AW +: AW] = AW'(1);
        req[1] = 1'b1;
        run_txn(1'b1, ackv, nsw, nsr, lat, rd, er);
        check("rd_ack", 32'(ackv), 32'h2);
        check("rd_rdata", 32'(rd), 32'h3C);
        check("rd_start_read_pulses", 32'(nsr), 32'd1);
        check("rd_start_write_pulses", 32'(nsw), 32'd0);
        check("rd_err", 32'(er), 32'd0);
        fixed_rdata = -1;

        // ---- contention after reset: 0,1,0,1 ----
        apply_reset();
        req_we = N'($urandom);
        req    = N'(3);
        for (int j = 0; j < 4; j++) begin
            run_txn(1'b0, ackv, nsw, nsr, lat, rd, er);
            check("cont_order", 32'(ackv), 32'(1 << exp_order[j]));
            check("cont_one_start", 32'(nsw + nsr), 32'd1);
        end
        req = '0;
        repeat (3) step();

        // ---- done held high after completion blocks the next start ----
        fixed_lat  = 2;
        fixed_hold = 3;
        req        = N'(1);
        run_txn(1'b0, ackv, nsw, nsr, lat, rd, er);
        check("guard_ack", 32'(ackv), 32'h1);
        fixed_hold = 0;
        first = -1;
        for (int j = 1; j <= 6; j++) begin
            step();
            if (first < 0 && (m_start_write || m_start_read)) first = j;
        end
        check("guard_first_start_step", 32'(first), 32'd4);
        run_txn(1'b1, ackv, nsw, nsr, lat, rd, er);
        check("guard_second_ack", 32'(ackv), 32'h1);
        fixed_lat = -1;
        repeat (2) step();

        // ---- reset during WAIT, then requester 1 alone wins first ----
        fixed_lat = -2;
        req       = N'(1);
        seen_busy = 1'b0;
        for (int j = 0; j < 10 && !seen_busy; j++) begin
            step();
            if (busy) seen_busy = 1'b1;
        end
        check("rst_txn_started", 32'(seen_busy), 32'd1);
        repeat (2) step();
        apply_reset();
        fixed_lat = 2;
        req       = N'(2);
        run_txn(1'b1, ackv, nsw, nsr, lat, rd, er);
        check("post_rst_first_grant", 32'(ackv), 32'h2);
        fixed_lat = -1;
        repeat (2) step();

`ifdef AXI4LITE_ARB_TIMEOUT_EN
        // ---- watchdog: done never arrives ----
        fixed_lat = -2;
        req       = N'(1);
        run_txn(1'b1, ackv, nsw, nsr, lat, rd, er);
        check("to_ack", 32'(ackv), 32'h1);
        check("to_err", 32'(er), 32'd1);
        check("to_rdata", 32'(rd), 32'd0);
        check("to_start_to_ack", 32'(lat), 32'(TO + 1));
        fixed_lat = -1;
        repeat (2) step();
`endif

        // ---- randomized traffic: levels and fields change every cycle ----
        for (int j = 0; j < 3000; j++) begin
            req       = (j % 2 == 0) ? N'($urandom) : N'($urandom) & N'($urandom);
            req_we    = N'($urandom);
            req_addr  = (N*AW)'($urandom);
            req_wdata = (N*DW)'($urandom);
            fixed_hold = ($urandom_range(0, 7) == 0) ? 2 : 0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
